partition_rr_arbiter: RTL and testbench
=======================================

Name: partition_rr_arbiter

Overview:
- Next-generation partition arbiter: merges NUM_OF_MAPPERS mapper output streams into one stream feeding the partition FIFO.
- Upgrades over the previous arbiter:
  - carries the data payload, not just a grant;
  - true round-robin that skips idle requesters;
  - configurable burst length per grant;
  - full-throughput valid/ready handshake on both sides instead of a fixed 2-cycle cadence.
- Sits between the mapper output FIFOs and the partition FIFO write port.

Parameters:
- NUM_OF_MAPPERS, 4, number of input channels (>=1).
- DATA_WIDTH, 64, payload width per beat.
- MAX_BURST, 1, maximum consecutive beats granted to one channel before priority rotates (>=1).

Ports:
- clock  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_OF_MAPPERS  per-channel beat available (mapper FIFO !empty).
- in_data  input  NUM_OF_MAPPERS*DATA_WIDTH  flattened payloads; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  NUM_OF_MAPPERS  one-hot pop to the winning channel (mapper FIFO re).
- out_valid  output  1  output register holds a beat (partition FIFO we).
- out_data  output  DATA_WIDTH  registered payload.
- out_grant  output  NUM_OF_MAPPERS  registered one-hot source of out_data.
- out_grant_idx  output  IDX_W  binary source index; IDX_W = max(1, clog2(NUM_OF_MAPPERS)).
- out_ready  input  1  downstream can accept (partition FIFO !full).

Behaviour:
- Reset (asynchronous, immediate):
  - out_valid=0, out_data=0, out_grant=0, out_grant_idx=0;
  - priority pointer=0, burst_cnt=0, state=EMPTY.
  - A beat in flight is discarded. in_ready=0 while reset is asserted.
- Handshake:
  - Input transfer on channel i when in_valid[i] && in_ready[i].
  - Output transfer when out_valid && out_ready.
- load = (state==EMPTY) || out_ready. in_ready is combinational: in_ready = load ? winner_onehot : 0. It never depends on out_valid of the same beat.
- Winner: first channel with in_valid set, scanning from ptr upward with wrap (ptr, ptr+1, ..., ptr-1 mod N). No in_valid set means no winner and in_ready=0.
- State machine:
  - EMPTY -> FULL when any input transfer occurs.
  - FULL -> FULL when the output transfers and an input transfers in the same cycle (back-to-back, 1 beat/cycle).
  - FULL -> EMPTY when the output transfers with no input transfer.
  - FULL holds when out_ready=0: out_data/out_grant stable, in_ready=0.
- Latency: input transfer at edge k gives out_valid=1 with that data from edge k+1 onward.
- Capture on input transfer from channel w: out_data<=in_data[w], out_grant<=onehot(w), out_grant_idx<=w.
- Pointer/burst update on input transfer from w:
  - If w==ptr and burst_cnt+1 < MAX_BURST: ptr unchanged, burst_cnt<=burst_cnt+1.
  - Otherwise: ptr<=(w+1) mod N, burst_cnt<=0.
  - When w != ptr, the first beat counts as beat 1 of a new burst: ptr<=w, burst_cnt<=1 if MAX_BURST>1; else ptr<=(w+1) mod N.
  - ptr wraps NUM_OF_MAPPERS-1 -> 0. burst_cnt width is clog2(MAX_BURST+1).
- Burst ends early if the burst channel drops in_valid; the next winner is chosen by the normal scan from ptr.
- NUM_OF_MAPPERS=1: channel 0 always wins when valid; ptr stays 0.
- No beat is lost or duplicated: each input transfer produces exactly one output transfer unless reset intervenes.

Optional Feature:
- Macro: PARTITION_ARB_STATS_EN.
- Defined:
  - Adds output port grant_count, width NUM_OF_MAPPERS*32; channel i at [i*32 +: 32].
  - Per-channel saturating counter (holds at 32'hFFFFFFFF), incremented on each input transfer from that channel.
  - Cleared by reset.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-FULL: N=4, load ch2 beat 0xAA, assert reset with out_ready=0 -> out_valid=0, out_data=0 immediately; the first grant after reset release goes to ch0 when all are valid.
- Fair rotation: N=4, MAX_BURST=1, all in_valid=1, out_ready=1 -> grants 0,1,2,3,0,... one per cycle, out_valid continuous after the first cycle.
- Skip idle: in_valid=4'b1010, ptr=0, MAX_BURST=1 -> grants 1,3,1,3; out_grant_idx sequence 1,3,1,3.
- Burst: MAX_BURST=3, all valid -> grants 0,0,0,1,1,1,2,...; if ch1 drops in_valid after its first beat, the next grant is ch2.
- Backpressure: out_ready=0 for 5 cycles while FULL with ch3 data 0x1234 -> out_data stable 0x1234, in_ready=0; after out_ready rises, next beat appears the following cycle, no loss.
- Stats (PARTITION_ARB_STATS_EN): 10 beats from ch1, 3 from ch2 -> grant_count ch1=10, ch2=3, others 0; force ch0 counter to 32'hFFFFFFFF, one more ch0 beat -> stays 32'hFFFFFFFF.

Source files
------------

// File: rtl/partition_rr_arbiter_if.sv
// Handshake bundle between the mapper output FIFOs, the partition arbiter and the partition FIFO.
// slave is the arbiter's view of the bundle; master is the view of the logic around it.
interface partition_rr_arbiter_if #(
    parameter int NUM_OF_MAPPERS = 4,
    parameter int DATA_WIDTH     = 64
);
    localparam int IDX_W = (NUM_OF_MAPPERS > 1) ? $clog2(NUM_OF_MAPPERS) : 1;

    logic [NUM_OF_MAPPERS-1:0]            in_valid;
    logic [NUM_OF_MAPPERS*DATA_WIDTH-1:0] in_data;
    logic [NUM_OF_MAPPERS-1:0]            in_ready;
    logic                                 out_valid;
    logic [DATA_WIDTH-1:0]                out_data;
    logic [NUM_OF_MAPPERS-1:0]            out_grant;
    logic [IDX_W-1:0]                     out_grant_idx;
    logic                                 out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_grant, out_grant_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_grant, out_grant_idx
    );
endinterface

// File: rtl/partition_rr_arbiter.sv
// Round-robin merge of NUM_OF_MAPPERS valid/ready streams into one registered output stream.
// Defining PARTITION_ARB_STATS_EN adds saturating per-channel grant counters on port grant_count.
module partition_rr_arbiter #(
    parameter int NUM_OF_MAPPERS = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int MAX_BURST      = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    partition_rr_arbiter_if.slave       bus
`ifdef PARTITION_ARB_STATS_EN
    ,
    output logic [NUM_OF_MAPPERS*32-1:0] grant_count
`endif
);
    localparam int IDX_W  = (NUM_OF_MAPPERS > 1) ? $clog2(NUM_OF_MAPPERS) : 1;
    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [BCNT_W-1:0]         burst_q, burst_d;
    logic [DATA_WIDTH-1:0]     out_data_q;
    logic [NUM_OF_MAPPERS-1:0] out_grant_q;
    logic [IDX_W-1:0]          out_idx_q;

    logic                      win_found;
    logic [IDX_W-1:0]          win_idx;
    logic [IDX_W-1:0]          cand;
    logic [NUM_OF_MAPPERS-1:0] win_onehot;
    logic                      load;
    logic                      take;

    // Scan from the priority pointer upward with wrap; first valid channel wins.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_OF_MAPPERS; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_OF_MAPPERS);
            if (!win_found && bus.in_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_onehot          = '0;
        win_onehot[win_idx] = win_found;
    end

    // The output register can take a new beat when it is empty or drains this cycle.
    assign load = (state_q == EMPTY) || bus.out_ready;
    assign take = load && win_found && !reset;

    assign bus.in_ready = take ? win_onehot : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;

        case (state_q)
            EMPTY:   if (take) state_d = FULL;
            FULL:    if (bus.out_ready && !take) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        if (take) begin
            if (win_idx == ptr_q && int'(burst_q) + 1 < MAX_BURST) begin
                burst_d = burst_q + 1'b1;
            end else if (win_idx != ptr_q && MAX_BURST > 1) begin
                // A grant away from the pointer opens a new burst on that channel.
                ptr_d   = win_idx;
                burst_d = BCNT_W'(1);
            end else begin
                ptr_d   = (int'(win_idx) == NUM_OF_MAPPERS - 1) ? '0 : win_idx + 1'b1;
                burst_d = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            ptr_q       <= '0;
            burst_q     <= '0;
            out_data_q  <= '0;
            out_grant_q <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            if (take) begin
                out_data_q  <= bus.in_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                out_grant_q <= win_onehot;
                out_idx_q   <= win_idx;
            end
        end
    end

    assign bus.out_valid     = (state_q == FULL);
    assign bus.out_data      = out_data_q;
    assign bus.out_grant     = out_grant_q;
    assign bus.out_grant_idx = out_idx_q;

`ifdef PARTITION_ARB_STATS_EN
    logic [NUM_OF_MAPPERS-1:0][31:0] cnt_q;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (take && cnt_q[win_idx] != 32'hFFFF_FFFF) begin
            cnt_q[win_idx] <= cnt_q[win_idx] + 32'd1;
        end
    end

    assign grant_count = cnt_q;
`endif
endmodule

// File: tb/tb_partition_rr_arbiter.sv
// Directed bench for partition_rr_arbiter: one instance with MAX_BURST=1 and one with MAX_BURST=3.
// Stats checks are compiled in when PARTITION_ARB_STATS_EN is defined.
module tb_partition_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    partition_rr_arbiter_if #(.NUM_OF_MAPPERS(N), .DATA_WIDTH(DW)) bus1 ();
    partition_rr_arbiter_if #(.NUM_OF_MAPPERS(N), .DATA_WIDTH(DW)) bus3 ();

`ifdef PARTITION_ARB_STATS_EN
    logic [N*32-1:0] gc1;
    logic [N*32-1:0] gc3;
`endif

    partition_rr_arbiter #(.NUM_OF_MAPPERS(N), .DATA_WIDTH(DW), .MAX_BURST(1)) u_dut_b1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
`ifdef PARTITION_ARB_STATS_EN
        ,
        .grant_count (gc1)
`endif
    );

    partition_rr_arbiter #(.NUM_OF_MAPPERS(N), .DATA_WIDTH(DW), .MAX_BURST(3)) u_dut_b3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
`ifdef PARTITION_ARB_STATS_EN
        ,
        .grant_count (gc3)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] chan_data(input int i);
        return 64'h0000_0000_0000_00D0 + 64'(i);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_grant;
        int         burst_exp [11] = '{0, 0, 0, 1, 2, 2, 2, 3, 3, 3, 0};

        bus1.in_valid  = '0;
        bus1.out_ready = 1'b0;
        bus3.in_valid  = '0;
        bus3.out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus1.in_data[i*DW +: DW] = chan_data(i);
            bus3.in_data[i*DW +: DW] = chan_data(i);
        end

        // Reset state, with in_ready held low while reset is asserted
        bus1.in_valid = 4'hF;
        #2;
        check("rst_in_ready", 64'(bus1.in_ready), 64'h0);
        check("rst_out_valid", 64'(bus1.out_valid), 64'h0);
        check("rst_out_data", bus1.out_data, 64'h0);
        check("rst_out_grant", 64'(bus1.out_grant), 64'h0);
        check("rst_out_idx", 64'(bus1.out_grant_idx), 64'h0);
        tick();
        bus1.in_valid = '0;
        @(negedge clock);
        reset = 1'b0;

        // Reset while FULL under backpressure
        bus1.in_valid = 4'b0100;
        bus1.in_data[2*DW +: DW] = 64'hAA;
        bus1.out_ready = 1'b0;
        #1;
        check("midrst_in_ready", 64'(bus1.in_ready), 64'h4);
        tick();
        check("midrst_loaded_valid", 64'(bus1.out_valid), 64'h1);
        check("midrst_loaded_data", bus1.out_data, 64'hAA);
        check("midrst_loaded_idx", 64'(bus1.out_grant_idx), 64'h2);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_async_valid", 64'(bus1.out_valid), 64'h0);
        check("midrst_async_data", bus1.out_data, 64'h0);
        check("midrst_async_grant", 64'(bus1.out_grant), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        bus1.in_data[2*DW +: DW] = chan_data(2);

        // Fair rotation with all channels valid
        bus1.in_valid  = 4'hF;
        bus1.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_grant = 4'b0001 << (k % 4);
            check($sformatf("rot_in_ready_%0d", k), 64'(bus1.in_ready), 64'(exp_grant));
            tick();
            check($sformatf("rot_valid_%0d", k), 64'(bus1.out_valid), 64'h1);
            check($sformatf("rot_idx_%0d", k), 64'(bus1.out_grant_idx), 64'(k % 4));
            check($sformatf("rot_data_%0d", k), bus1.out_data, chan_data(k % 4));
        end
        bus1.in_valid = '0;
        tick();
        check("rot_drain_valid", 64'(bus1.out_valid), 64'h0);

        // Skip idle requesters
        pulse_reset();
        bus1.in_valid  = 4'b1010;
        bus1.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("skip_idx_%0d", k), 64'(bus1.out_grant_idx), (k % 2 == 1) ? 64'h3 : 64'h1);
            check($sformatf("skip_grant_%0d", k), 64'(bus1.out_grant), (k % 2 == 1) ? 64'h8 : 64'h2);
        end
        bus1.in_valid = '0;
        tick();

        // Backpressure holds the output register and blocks inputs
        pulse_reset();
        bus1.in_valid  = 4'b1000;
        bus1.in_data[3*DW +: DW] = 64'h1234;
        bus1.out_ready = 1'b0;
        tick();
        check("bp_first_data", bus1.out_data, 64'h1234);
        bus1.in_data[3*DW +: DW] = 64'h5678;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp_in_ready_%0d", k), 64'(bus1.in_ready), 64'h0);
            tick();
            check($sformatf("bp_hold_data_%0d", k), bus1.out_data, 64'h1234);
            check($sformatf("bp_hold_valid_%0d", k), 64'(bus1.out_valid), 64'h1);
        end
        bus1.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(bus1.in_ready), 64'h8);
        tick();
        check("bp_next_data", bus1.out_data, 64'h5678);
        check("bp_next_valid", 64'(bus1.out_valid), 64'h1);
        bus1.in_valid = '0;
        tick();
        check("bp_drain_valid", 64'(bus1.out_valid), 64'h0);
        bus1.in_data[3*DW +: DW] = chan_data(3);

        // Bursts of three, ch1 drops after its first beat
        pulse_reset();
        bus3.in_valid  = 4'hF;
        bus3.out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k >= 4) bus3.in_valid = 4'b1101;
            tick();
            check($sformatf("burst_idx_%0d", k), 64'(bus3.out_grant_idx), 64'(burst_exp[k]));
        end
        bus3.in_valid = '0;
        tick();

`ifdef PARTITION_ARB_STATS_EN
        // Per-channel grant counters and saturation
        pulse_reset();
        bus1.out_ready = 1'b1;
        bus1.in_valid  = 4'b0010;
        repeat (10) tick();
        bus1.in_valid  = 4'b0100;
        repeat (3) tick();
        bus1.in_valid  = '0;
        tick();
        check("stats_ch0", 64'(gc1[0 +: 32]), 64'd0);
        check("stats_ch1", 64'(gc1[32 +: 32]), 64'd10);
        check("stats_ch2", 64'(gc1[64 +: 32]), 64'd3);
        check("stats_ch3", 64'(gc1[96 +: 32]), 64'd0);
        force u_dut_b1.cnt_q[0] = 32'hFFFF_FFFF;
        #1;
        release u_dut_b1.cnt_q[0];
        bus1.in_valid = 4'b0001;
        tick();
        bus1.in_valid = '0;
        tick();
        check("stats_sat_ch0", 64'(gc1[0 +: 32]), 64'h0000_0000_FFFF_FFFF);
        check("stats_sat_ch1", 64'(gc1[32 +: 32]), 64'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
